// File: rtl/dram_pkg.sv
// Shared types and constants for the data RAM slice: access-size encoding,
// clear-FSM states, the default depth and the erroneous-access rule.
package dram_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 64;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // An access is erroneous when its size is reserved or its low address
    // bits are not aligned to the access width.
    function automatic logic isErrAccess(input logic [1:0] size, input logic [1:0] addrLo);
        case (size_e'(size))
            SZ_HALF: isErrAccess = addrLo[0];
            SZ_WORD: isErrAccess = |addrLo;
            SZ_RSVD: isErrAccess = 1'b1;
            default: isErrAccess = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dram_lane_fmt.sv
// Byte-lane formatting for the data RAM: store byte enables and lane
// replication, load lane selection and sign extension.
// Build option: DRAM_MISALIGN_TRAP_EN suppresses misaligned stores and zeroes
// misaligned loads; without it the low address bits are simply forced aligned.
module dram_lane_fmt
    import dram_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  store_size_i,
    input  logic [1:0]  load_size_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o,
    output logic        store_err_o,
    output logic        load_err_o
);

    logic [7:0]  selByte;
    logic [15:0] selHalf;

    // Store side: replicate the data across lanes and enable only the lanes covered.
    always_comb begin
        store_err_o = isErrAccess(store_size_i, addr_lo_i);
        be_o        = 4'b0000;
        wlane_o     = wdata_i;
        case (size_e'(store_size_i))
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wlane_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wlane_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wlane_o = wdata_i;
            end
            default: be_o = 4'b0000;
        endcase
`ifdef DRAM_MISALIGN_TRAP_EN
        if (store_err_o) begin
            be_o = 4'b0000;
        end
`endif
    end

    // Load side: pick the addressed lane(s) from the word and sign-extend.
    always_comb begin
        load_err_o = isErrAccess(load_size_i, addr_lo_i);
        case (addr_lo_i)
            2'd0:    selByte = rword_i[7:0];
            2'd1:    selByte = rword_i[15:8];
            2'd2:    selByte = rword_i[23:16];
            default: selByte = rword_i[31:24];
        endcase
        selHalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_e'(load_size_i))
            SZ_BYTE: rdata_o = {{24{selByte[7]}}, selByte};
            SZ_HALF: rdata_o = {{16{selHalf[15]}}, selHalf};
            SZ_WORD: rdata_o = rword_i;
            default: rdata_o = 32'h0;
        endcase
`ifdef DRAM_MISALIGN_TRAP_EN
        if (load_err_o) begin
            rdata_o = 32'h0;
        end
`endif
    end

endmodule

// File: rtl/data_ram.sv
// Word-organised data RAM for the core with byte/half/word access, a
// post-reset clear sequence and sticky misalignment error reporting.
// Build option: DRAM_MISALIGN_TRAP_EN (see dram_lane_fmt) selects trap
// behaviour for misaligned accesses; the default build forces alignment.
module data_ram
    import dram_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_wr_en,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    input  logic [1:0]  store_size,
    input  logic [1:0]  load_size,
    output logic [31:0] dRdata,
    output logic        init_busy,
    output logic        misalign_err,
    output logic [7:0]  err_count
);

    logic [31:0]       mem [DEPTH_WORDS];
    state_e            state_q;
    logic [ADDR_W-1:0] clrIdx_q;
    logic              misalignErr_q;
    logic              misalignErr_d;
    logic [7:0]        errCount_q;
    logic [7:0]        errCount_d;

    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       rword;
    logic [3:0]        fmtBe;
    logic [31:0]       fmtWlane;
    logic [31:0]       fmtRdata;
    logic              storeErr;
    logic              loadErr;
    logic              errCycle;
    logic [ADDR_W-1:0] wrIdx;
    logic [3:0]        wrBe;
    logic [31:0]       wrData;
    logic              unusedAddrHi;

    // Address bits above the array wrap silently.
    assign wordIdx      = dAddr[ADDR_W+1:2];
    assign unusedAddrHi = ^dAddr[31:ADDR_W+2];
    assign rword        = mem[wordIdx];

    dram_lane_fmt u_lane_fmt (
        .addr_lo_i    (dAddr[1:0]),
        .store_size_i (store_size),
        .load_size_i  (load_size),
        .wdata_i      (dWdata),
        .rword_i      (rword),
        .be_o         (fmtBe),
        .wlane_o      (fmtWlane),
        .rdata_o      (fmtRdata),
        .store_err_o  (storeErr),
        .load_err_o   (loadErr)
    );

    // Clear FSM: zero one word per cycle after reset, then stay READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrIdx_q <= '0;
        end else if (state_q == CLEAR) begin
            if (clrIdx_q == ADDR_W'(DEPTH_WORDS - 1)) begin
                state_q <= READY;
            end
            clrIdx_q <= clrIdx_q + ADDR_W'(1);
        end
    end

    // Error detection on the active access; the counter saturates at 255.
    always_comb begin
        errCycle      = (state_q == READY) && (d_wr_en ? storeErr : loadErr);
        misalignErr_d = misalignErr_q | errCycle;
        errCount_d    = errCount_q;
        if (errCycle && (errCount_q != 8'hFF)) begin
            errCount_d = errCount_q + 8'd1;
        end
    end

    // Error flag and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalignErr_q <= 1'b0;
            errCount_q    <= 8'd0;
        end else begin
            misalignErr_q <= misalignErr_d;
            errCount_q    <= errCount_d;
        end
    end

    // Single write port shared by the clear sequence and core stores.
    always_comb begin
        wrIdx  = wordIdx;
        wrBe   = 4'b0000;
        wrData = fmtWlane;
        if (state_q == CLEAR) begin
            wrIdx  = clrIdx_q;
            wrBe   = 4'b1111;
            wrData = 32'h0;
        end else if (d_wr_en) begin
            wrBe = fmtBe;
        end
    end

    // Array write; contents are never reset directly, only by the clear sequence.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wrBe[i]) begin
                mem[wrIdx][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
    end

    assign init_busy    = (state_q == CLEAR);
    assign dRdata       = (state_q == CLEAR) ? 32'h0 : fmtRdata;
    assign misalign_err = misalignErr_q;
    assign err_count    = errCount_q;

endmodule
